onchip_mem_tester: RTL and testbench

- Avalon-MM master that drives the 1 K x 32 single-port on-chip RAM slave (s1) from the other end of the bus.
- On a start pulse it fills a window of memory with a generated pattern, reads the window back, and compares each word.
- Reports pass/fail, error count and first failing address.
- Used as a power-on and debug self-test of the lab1 on-chip memory, alongside the CPU master.

---
 rtl/onchip_mem_tester_pkg.sv | 30 +++
 rtl/onchip_mem_tester_if.sv | 42 ++++
 rtl/mem_pattern_gen.sv | 53 +++++
 rtl/onchip_mem_tester.sv | 226 ++++++++++++++++++++++
 tb/tb_onchip_mem_tester.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_tester_pkg.sv
// Shared definitions for the on-chip memory tester.
//   state_e     : controller FSM states
//   MEM_WORDS   : number of words in the RAM under test (address wraps at this size)
//   LFSR_TAPS   : Galois feedback taps of the optional pseudo-random pattern
//   pattern_step: one LFSR step; used only when ONCHIP_MEM_TESTER_LFSR_EN is defined
package onchip_mem_tester_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRdIssue = 3'd2,
    StRdWait  = 3'd3,
    StFinish  = 3'd4
  } state_e;

  localparam int unsigned MEM_WORDS = 1024;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois LFSR: the bit shifted out selects whether the taps are applied.
  function automatic logic [31:0] pattern_step(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/onchip_mem_tester_if.sv
// Avalon-MM bus between the tester (master) and the on-chip RAM slave.
//   avm_address     : word address
//   avm_chipselect  : access strobe
//   avm_write       : 1 = write, 0 = read (qualified by chipselect)
//   avm_byteenable  : byte lanes, DATA_W/8 bits
//   avm_writedata   : write data
//   avm_waitrequest : slave stall
//   avm_readdata    : read data
interface onchip_mem_tester_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_byteenable,
    output avm_writedata,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_byteenable,
    input  avm_writedata,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/mem_pattern_gen.sv
// Test pattern generator for the memory tester.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_load         : load the generator from i_seed (takes priority over i_step)
//   i_step         : advance to the next pattern word
//   i_seed         : seed value
//   o_pattern      : current pattern word
// Default build: incrementing pattern (seed, seed+1, ...).
// With ONCHIP_MEM_TESTER_LFSR_EN defined: 32-bit Galois LFSR, a zero seed is replaced by 1.
module mem_pattern_gen
  import onchip_mem_tester_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_seed,
  output logic [DATA_W-1:0] o_pattern
);

  logic [DATA_W-1:0] r_pat;
  logic [DATA_W-1:0] w_pat_next;

  always_comb begin
    w_pat_next = r_pat;
    if (i_load) begin
`ifdef ONCHIP_MEM_TESTER_LFSR_EN
      // An all-zero LFSR state would lock up.
      w_pat_next = (i_seed == '0) ? DATA_W'(1) : i_seed;
`else
      w_pat_next = i_seed;
`endif
    end else if (i_step) begin
`ifdef ONCHIP_MEM_TESTER_LFSR_EN
      w_pat_next = pattern_step(r_pat);
`else
      w_pat_next = r_pat + DATA_W'(1);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pat <= '0;
    end else begin
      r_pat <= w_pat_next;
    end
  end

  assign o_pattern = r_pat;

endmodule

// File: rtl/onchip_mem_tester.sv
// Avalon-MM memory self-tester: fills a window of the on-chip RAM with a pattern,
// reads it back one word at a time and reports the comparison result.
//   i_clk, i_reset     : clock, asynchronous active-high reset
//   i_start            : one-cycle start pulse, ignored while a test is running
//   i_base_addr        : first word address of the window (wraps at MEM_WORDS)
//   i_num_words        : window length, clamped to MEM_WORDS
//   i_seed             : pattern seed
//   o_busy             : test in progress
//   o_done             : one-cycle completion pulse
//   o_pass             : result of the last test, held until the next start
//   o_err_count        : saturating mismatch count
//   o_first_err_addr   : address of the first mismatch, 0 if none
//   avm_bus            : Avalon-MM master port
// Optional: ONCHIP_MEM_TESTER_LFSR_EN selects an LFSR pattern instead of an incrementing one.
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ERR_W        = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [ADDR_W:0]     i_num_words,
  input  logic [DATA_W-1:0]   i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [ERR_W-1:0]    o_err_count,
  output logic [ADDR_W-1:0]   o_first_err_addr,
  onchip_mem_tester_if.master avm_bus
);

  localparam int unsigned     LAT_W        = 3;
  localparam logic [ADDR_W:0] LP_MEM_WORDS = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [LAT_W-1:0] LP_LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_last_idx;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_seed;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err_count;
  logic [ADDR_W-1:0]   r_first_err;

  logic [ADDR_W:0]     w_len;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_accept;
  logic                w_last;
  logic                w_lat_done;
  logic                w_mismatch;
  logic                w_cs;
  logic                w_wr;
  logic                w_load;
  logic                w_step;
  logic [DATA_W-1:0]   w_gen_seed;
  logic [DATA_W-1:0]   w_pattern;

  assign w_len      = (i_num_words > LP_MEM_WORDS) ? LP_MEM_WORDS : i_num_words;
  // Natural truncation gives the modulo-MEM_WORDS wrap of the window.
  assign w_addr     = r_base + r_idx;
  assign w_accept   = ~avm_bus.avm_waitrequest;
  assign w_last     = (r_idx == r_last_idx);
  assign w_lat_done = (r_lat_cnt == LP_LAT_LAST);
  assign w_mismatch = (avm_bus.avm_readdata != w_pattern);
  // Idle loads the live seed; the read phase reloads the latched one.
  assign w_gen_seed = (r_state == StIdle) ? i_seed : r_seed;

  mem_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_seed    (w_gen_seed),
    .o_pattern (w_pattern)
  );

  // Next state and bus strobes. Strobes depend on state only, so an asynchronous
  // reset releases the bus immediately.
  always_comb begin
    w_state_next = r_state;
    w_cs         = 1'b0;
    w_wr         = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = (w_len == '0) ? StFinish : StWrite;
        end
      end
      StWrite: begin
        w_cs = 1'b1;
        w_wr = 1'b1;
        if (w_accept) begin
          if (w_last) begin
            w_load       = 1'b1;
            w_state_next = StRdIssue;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      StRdIssue: begin
        w_cs = 1'b1;
        if (w_accept) begin
          w_state_next = StRdWait;
        end
      end
      StRdWait: begin
        if (w_lat_done) begin
          if (w_last) begin
            w_state_next = StFinish;
          end else begin
            w_step       = 1'b1;
            w_state_next = StRdIssue;
          end
        end
      end
      StFinish: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base      <= '0;
      r_last_idx  <= '0;
      r_idx       <= '0;
      r_seed      <= '0;
      r_lat_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_first_err <= '0;
    end else begin
      r_done <= (r_state == StFinish);
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_base      <= i_base_addr;
            // Unused when the window is empty (the FSM skips straight to StFinish).
            r_last_idx  <= ADDR_W'(w_len - (ADDR_W + 1)'(1));
            r_seed      <= i_seed;
            r_idx       <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        StWrite: begin
          if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + ADDR_W'(1);
          end
        end
        StRdIssue: begin
          if (w_accept) begin
            r_lat_cnt <= '0;
          end
        end
        StRdWait: begin
          if (!w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end else begin
            if (w_mismatch) begin
              if (r_err_count != '1) begin
                r_err_count <= r_err_count + ERR_W'(1);
              end
              // A zero count means no earlier mismatch in this test.
              if (r_err_count == '0) begin
                r_first_err <= w_addr;
              end
            end
            if (!w_last) begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end
        end
        StFinish: begin
          r_pass <= (r_err_count == '0);
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign avm_bus.avm_chipselect = w_cs;
  assign avm_bus.avm_write      = w_wr;
  assign avm_bus.avm_address    = w_cs ? w_addr : '0;
  assign avm_bus.avm_writedata  = w_wr ? w_pattern : '0;
  assign avm_bus.avm_byteenable = '1;

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err;

endmodule

// File: tb/tb_onchip_mem_tester.sv
// Directed self-checking bench for onchip_mem_tester (default incrementing-pattern build)
// with a behavioural 1K x 32 RAM slave, read latency 1, fault and stall injection.
module tb_onchip_mem_tester;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   num_words;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onchip_mem_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  onchip_mem_tester #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (1),
    .ERR_W        (ERR_W)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .i_base_addr      (base),
    .i_num_words      (num_words),
    .i_seed           (seed),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_err_count      (err_count),
    .o_first_err_addr (first_err_addr),
    .avm_bus          (mem_bus)
  );

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [1024];
  int          wr_total = 0;
  int          rd_total = 0;
  int          cs_total = 0;
  logic [9:0]  wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  bit          fault_en = 1'b0;
  logic [9:0]  fault_a0 = '0;
  logic [9:0]  fault_a1 = '0;
  bit          stall_en = 1'b0;
  int          stall_at = 0;
  int          stall_left = 3;
  int          stall_cycles = 0;
  logic [9:0]  st_addr = '0;
  logic [31:0] st_data = '0;
  bit          st_unstable = 1'b0;

  assign mem_bus.avm_waitrequest = stall_en && mem_bus.avm_chipselect && mem_bus.avm_write &&
                                   (wr_total == stall_at) && (stall_left > 0);

  always @(posedge clk) begin
    if (mem_bus.avm_chipselect) begin
      cs_total <= cs_total + 1;
      if (mem_bus.avm_waitrequest) begin
        stall_left   <= stall_left - 1;
        stall_cycles <= stall_cycles + 1;
        if (stall_cycles == 0) begin
          st_addr <= mem_bus.avm_address;
          st_data <= mem_bus.avm_writedata;
        end else if (mem_bus.avm_address != st_addr || mem_bus.avm_writedata != st_data ||
                     !mem_bus.avm_write) begin
          st_unstable <= 1'b1;
        end
      end else if (mem_bus.avm_write) begin
        if (stall_en && wr_total == stall_at &&
            (mem_bus.avm_address != st_addr || mem_bus.avm_writedata != st_data)) begin
          st_unstable <= 1'b1;
        end
        mem[mem_bus.avm_address] <= mem_bus.avm_writedata;
        wr_total <= wr_total + 1;
        wr_addr_log.push_back(mem_bus.avm_address);
        wr_data_log.push_back(mem_bus.avm_writedata);
      end else begin
        rd_total <= rd_total + 1;
        if (fault_en && mem_bus.avm_address == fault_a0) begin
          mem_bus.avm_readdata <= 32'hDEAD_BEEF;
        end else if (fault_en && mem_bus.avm_address == fault_a1) begin
          mem_bus.avm_readdata <= 32'h0000_0000;
        end else begin
          mem_bus.avm_readdata <= mem[mem_bus.avm_address];
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start, then wait (bounded) for done. lat = negedges from the start-sampling edge.
  task automatic run_test(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s,
                          output int lat, output bit got_done, output bit busy_after);
    @(negedge clk);
    base      = b;
    num_words = n;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    busy_after = busy;
    lat        = 1;
    got_done   = 1'b0;
    while (!got_done && lat < 20000) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          ok;
    bit          bz;
    int          w0;
    int          r0;
    int          c0;
    int          bad;
    int          dn;
    logic [9:0]  exp_a [8];

    rst       = 1'b1;
    start     = 1'b0;
    base      = '0;
    num_words = '0;
    seed      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_first", 32'(first_err_addr), 32'd0);
    check_eq("rst_cs", 32'(mem_bus.avm_chipselect), 32'd0);
    check_eq("rst_wr", 32'(mem_bus.avm_write), 32'd0);
    check_eq("rst_addr", 32'(mem_bus.avm_address), 32'd0);
    check_eq("rst_wdata", mem_bus.avm_writedata, 32'd0);
    check_eq("rst_be", 32'(mem_bus.avm_byteenable), 32'hF);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: base 0, 16 words, seed 0x1000
    w0 = wr_total;
    r0 = rd_total;
    run_test(10'd0, 11'd16, 32'h1000, lat, ok, bz);
    check_eq("t1_done", 32'(ok), 32'd1);
    check_eq("t1_busy", 32'(bz), 32'd1);
    check_eq("t1_latency", 32'(lat), 32'd50);
    check_eq("t1_writes", 32'(wr_total - w0), 32'd16);
    check_eq("t1_reads", 32'(rd_total - r0), 32'd16);
    check_eq("t1_wdata_first", wr_data_log[w0], 32'h1000);
    check_eq("t1_wdata_last", wr_data_log[w0 + 15], 32'h100F);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_data_log[w0 + i] != 32'h1000 + 32'(i) || wr_addr_log[w0 + i] != 10'(i)) bad++;
    end
    check_eq("t1_wlog_bad", 32'(bad), 32'd0);
    check_eq("t1_pass", 32'(pass), 32'd1);
    check_eq("t1_err", 32'(err_count), 32'd0);
    check_eq("t1_first", 32'(first_err_addr), 32'd0);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // Test 2: wrap-around window
    exp_a = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
    w0 = wr_total;
    run_test(10'd1020, 11'd8, 32'h0000_00A0, lat, ok, bz);
    check_eq("t2_done", 32'(ok), 32'd1);
    check_eq("t2_writes", 32'(wr_total - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_addr%0d", i), 32'(wr_addr_log[w0 + i]), 32'(exp_a[i]));
    end
    check_eq("t2_pass", 32'(pass), 32'd1);

    // Test 3: two read faults at words 5 and 9
    fault_a0 = 10'd5;
    fault_a1 = 10'd9;
    fault_en = 1'b1;
    run_test(10'd0, 11'd16, 32'h1000, lat, ok, bz);
    fault_en = 1'b0;
    check_eq("t3_done", 32'(ok), 32'd1);
    check_eq("t3_err", 32'(err_count), 32'd2);
    check_eq("t3_first", 32'(first_err_addr), 32'd5);
    check_eq("t3_pass", 32'(pass), 32'd0);

    // Test 4: empty window
    c0 = cs_total;
    run_test(10'd100, 11'd0, 32'd5, lat, ok, bz);
    check_eq("t4_done", 32'(ok), 32'd1);
    check_eq("t4_latency", 32'(lat), 32'd2);
    check_eq("t4_cs_cycles", 32'(cs_total - c0), 32'd0);
    check_eq("t4_pass", 32'(pass), 32'd1);
    check_eq("t4_err", 32'(err_count), 32'd0);

    // Test 5: 3-cycle stall on the third write
    w0       = wr_total;
    stall_at = wr_total + 2;
    stall_en = 1'b1;
    run_test(10'd0, 11'd8, 32'h2000, lat, ok, bz);
    stall_en = 1'b0;
    check_eq("t5_done", 32'(ok), 32'd1);
    check_eq("t5_writes", 32'(wr_total - w0), 32'd8);
    check_eq("t5_stall_cycles", 32'(stall_cycles), 32'd3);
    check_eq("t5_stall_addr", 32'(st_addr), 32'd2);
    check_eq("t5_stall_data", st_data, 32'h2002);
    check_eq("t5_unstable", 32'(st_unstable), 32'd0);
    check_eq("t5_latency", 32'(lat), 32'd29);
    check_eq("t5_pass", 32'(pass), 32'd1);

    // Test 6: oversize window is clamped
    w0 = wr_total;
    run_test(10'd0, 11'd2000, 32'd7, lat, ok, bz);
    check_eq("t6_done", 32'(ok), 32'd1);
    check_eq("t6_writes", 32'(wr_total - w0), 32'd1024);
    check_eq("t6_pass", 32'(pass), 32'd1);

    // Test 7: reset mid-write
    @(negedge clk);
    base      = 10'd0;
    num_words = 11'd64;
    seed      = 32'h3000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t7_cs_before", 32'(mem_bus.avm_chipselect), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t7_cs_reset", 32'(mem_bus.avm_chipselect), 32'd0);
    check_eq("t7_wr_reset", 32'(mem_bus.avm_write), 32'd0);
    check_eq("t7_busy_reset", 32'(busy), 32'd0);
    check_eq("t7_pass_reset", 32'(pass), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("t7_no_done", 32'(dn), 32'd0);
    run_test(10'd0, 11'd4, 32'h40, lat, ok, bz);
    check_eq("t7_rerun_done", 32'(ok), 32'd1);
    check_eq("t7_rerun_latency", 32'(lat), 32'd14);
    check_eq("t7_rerun_pass", 32'(pass), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
